// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions: register-slice mode encoding and the default channel,
// request and response structs used by the interconnect.
package axi4_pkg;

    localparam int unsigned SLICE_BYPASS = 0;
    localparam int unsigned SLICE_FULL   = 1;
    localparam int unsigned SLICE_HALF   = 2;
    localparam int unsigned SLICE_FWD    = 3;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } axi_ax_chan_t;

    typedef axi_ax_chan_t axi_aw_chan_t;
    typedef axi_ax_chan_t axi_ar_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        axi_b_chan_t b;
        logic        b_valid;
        axi_r_chan_t r;
        logic        r_valid;
    } axi_resp_t;

endpackage

// File: rtl/hs_reg_slice.sv
// Single valid/ready register slice with a compile-time choice of bypass,
// two-entry skid, half-throughput or forward-only buffering.
module hs_reg_slice
    import axi4_pkg::*;
#(
    parameter type         data_t = logic,
    parameter int unsigned MODE   = SLICE_FULL
) (
    input  logic  clk_i,
    input  logic  arst_ni,
    input  data_t in_data_i,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    output data_t out_data_o,
    output logic  out_valid_o,
    input  logic  out_ready_i
);

    if (MODE == SLICE_FULL) begin : g_full
        data_t main_data_reg, skid_data_reg;
        logic  main_valid_reg, skid_valid_reg;
        logic  in_fire, main_free;

        // Ready depends only on the skid flop, so no ready path crosses the slice.
        assign in_ready_o  = !skid_valid_reg;
        assign in_fire     = in_valid_i && !skid_valid_reg;
        assign main_free   = !main_valid_reg || out_ready_i;
        assign out_valid_o = main_valid_reg;
        assign out_data_o  = main_data_reg;

        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                main_data_reg  <= '0;
                skid_data_reg  <= '0;
                main_valid_reg <= 1'b0;
                skid_valid_reg <= 1'b0;
            end else if (main_free) begin
                if (skid_valid_reg) begin
                    main_data_reg  <= skid_data_reg;
                    main_valid_reg <= 1'b1;
                    skid_valid_reg <= 1'b0;
                end else begin
                    main_valid_reg <= in_fire;
                    if (in_fire) main_data_reg <= in_data_i;
                end
            end else if (in_fire) begin
                skid_data_reg  <= in_data_i;
                skid_valid_reg <= 1'b1;
            end
        end
    end else if (MODE == SLICE_HALF || MODE == SLICE_FWD) begin : g_single
        data_t main_data_reg;
        logic  main_valid_reg;
        logic  in_fire;

        // Forward-only may refill while draining; half mode waits for an empty slot.
        if (MODE == SLICE_FWD) begin : g_fwd_ready
            assign in_ready_o = !main_valid_reg || out_ready_i;
        end else begin : g_half_ready
            assign in_ready_o = !main_valid_reg;
        end

        assign in_fire     = in_valid_i && in_ready_o;
        assign out_valid_o = main_valid_reg;
        assign out_data_o  = main_data_reg;

        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                main_data_reg  <= '0;
                main_valid_reg <= 1'b0;
            end else if (in_fire) begin
                main_data_reg  <= in_data_i;
                main_valid_reg <= 1'b1;
            end else if (out_ready_i) begin
                main_valid_reg <= 1'b0;
            end
        end
    end else begin : g_bypass
        logic unused_clk_rst;

        assign unused_clk_rst = clk_i ^ arst_ni;
        assign out_data_o     = in_data_i;
        assign out_valid_o    = in_valid_i;
        assign in_ready_o     = out_ready_i;
    end

    if (MODE == SLICE_FULL || MODE == SLICE_HALF || MODE == SLICE_FWD) begin : g_stable_chk
        logic [$bits(data_t)-1:0] out_bits;

        assign out_bits = out_data_o;

        a_out_stable: assert property (@(posedge clk_i) disable iff (!arst_ni)
            (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(out_bits)));
    end

endmodule

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: five independent channel slices; everything outside the
// five handshakes is passed straight through.
module axi4_reg_slice
    import axi4_pkg::*;
#(
    parameter type         aw_chan_t = axi_aw_chan_t,
    parameter type         w_chan_t  = axi_w_chan_t,
    parameter type         b_chan_t  = axi_b_chan_t,
    parameter type         ar_chan_t = axi_ar_chan_t,
    parameter type         r_chan_t  = axi_r_chan_t,
    parameter type         req_t     = axi_req_t,
    parameter type         resp_t    = axi_resp_t,
    parameter int unsigned AW_MODE   = SLICE_FULL,
    parameter int unsigned W_MODE    = SLICE_FULL,
    parameter int unsigned B_MODE    = SLICE_FULL,
    parameter int unsigned AR_MODE   = SLICE_FULL,
    parameter int unsigned R_MODE    = SLICE_FULL
) (
    input  logic  clk_i,
    input  logic  arst_ni,
    input  req_t  mgr_req_i,
    output resp_t mgr_resp_o,
    output req_t  sub_req_o,
    input  resp_t sub_resp_i
);

    aw_chan_t aw_data;
    w_chan_t  w_data;
    b_chan_t  b_data;
    ar_chan_t ar_data;
    r_chan_t  r_data;
    logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic ar_valid, ar_ready, r_valid, r_ready;

    hs_reg_slice #(.data_t(aw_chan_t), .MODE(AW_MODE)) i_aw (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .in_data_i(mgr_req_i.aw), .in_valid_i(mgr_req_i.aw_valid), .in_ready_o(aw_ready),
        .out_data_o(aw_data), .out_valid_o(aw_valid), .out_ready_i(sub_resp_i.aw_ready)
    );

    hs_reg_slice #(.data_t(w_chan_t), .MODE(W_MODE)) i_w (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .in_data_i(mgr_req_i.w), .in_valid_i(mgr_req_i.w_valid), .in_ready_o(w_ready),
        .out_data_o(w_data), .out_valid_o(w_valid), .out_ready_i(sub_resp_i.w_ready)
    );

    hs_reg_slice #(.data_t(b_chan_t), .MODE(B_MODE)) i_b (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .in_data_i(sub_resp_i.b), .in_valid_i(sub_resp_i.b_valid), .in_ready_o(b_ready),
        .out_data_o(b_data), .out_valid_o(b_valid), .out_ready_i(mgr_req_i.b_ready)
    );

    hs_reg_slice #(.data_t(ar_chan_t), .MODE(AR_MODE)) i_ar (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .in_data_i(mgr_req_i.ar), .in_valid_i(mgr_req_i.ar_valid), .in_ready_o(ar_ready),
        .out_data_o(ar_data), .out_valid_o(ar_valid), .out_ready_i(sub_resp_i.ar_ready)
    );

    hs_reg_slice #(.data_t(r_chan_t), .MODE(R_MODE)) i_r (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .in_data_i(sub_resp_i.r), .in_valid_i(sub_resp_i.r_valid), .in_ready_o(r_ready),
        .out_data_o(r_data), .out_valid_o(r_valid), .out_ready_i(mgr_req_i.r_ready)
    );

    // Start from the incoming struct so any extra fields flow through untouched.
    always_comb begin
        sub_req_o          = mgr_req_i;
        sub_req_o.aw       = aw_data;
        sub_req_o.aw_valid = aw_valid;
        sub_req_o.w        = w_data;
        sub_req_o.w_valid  = w_valid;
        sub_req_o.ar       = ar_data;
        sub_req_o.ar_valid = ar_valid;
        sub_req_o.b_ready  = b_ready;
        sub_req_o.r_ready  = r_ready;
    end

    always_comb begin
        mgr_resp_o          = sub_resp_i;
        mgr_resp_o.aw_ready = aw_ready;
        mgr_resp_o.w_ready  = w_ready;
        mgr_resp_o.ar_ready = ar_ready;
        mgr_resp_o.b        = b_data;
        mgr_resp_o.b_valid  = b_valid;
        mgr_resp_o.r        = r_data;
        mgr_resp_o.r_valid  = r_valid;
    end

endmodule

// File: tb/tb_axi4_reg_slice.sv
// Scoreboard bench for axi4_reg_slice with AW bypass, W/AR full skid, R half, B forward-only.
module tb_axi4_reg_slice;
    import axi4_pkg::*;

    logic      clk_i = 1'b0;
    logic      arst_ni;
    axi_req_t  mgr_req, sub_req;
    axi_resp_t mgr_resp, sub_resp;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wq[$];
    logic [32:0] rq[$];
    logic [5:0]  bq[$];

    always #5 clk_i = ~clk_i;

    axi4_reg_slice #(
        .req_t(axi_req_t), .resp_t(axi_resp_t),
        .AW_MODE(SLICE_BYPASS), .W_MODE(SLICE_FULL), .B_MODE(SLICE_FWD),
        .AR_MODE(SLICE_FULL), .R_MODE(SLICE_HALF)
    ) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .mgr_req_i(mgr_req), .mgr_resp_o(mgr_resp),
        .sub_req_o(sub_req), .sub_resp_i(sub_resp)
    );

    task automatic test_reset();
        #3;
        checks++;
        if ({sub_req.aw_valid, sub_req.w_valid, sub_req.ar_valid, mgr_resp.b_valid, mgr_resp.r_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_valids got=%b exp=00000",
                     {sub_req.aw_valid, sub_req.w_valid, sub_req.ar_valid, mgr_resp.b_valid, mgr_resp.r_valid});
        end
        checks++;
        if ({mgr_resp.w_ready, mgr_resp.ar_ready, sub_req.b_ready, sub_req.r_ready, mgr_resp.aw_ready} !== 5'b11111) begin
            failures++;
            $display("FAIL reset_readys got=%b exp=11111",
                     {mgr_resp.w_ready, mgr_resp.ar_ready, sub_req.b_ready, sub_req.r_ready, mgr_resp.aw_ready});
        end
        sub_resp.aw_ready = 1'b0;
        #1;
        checks++;
        if (mgr_resp.aw_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_aw_ready_follow got=%b exp=0", mgr_resp.aw_ready);
        end
        @(negedge clk_i);
        arst_ni = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_ar_full();
        @(posedge clk_i); #1;
        mgr_req.ar_valid = 1'b1;
        mgr_req.ar.addr  = 32'h1000;
        mgr_req.ar.id    = 4'd3;
        sub_resp.ar_ready = 1'b1;
        @(negedge clk_i);
        checks++;
        if (mgr_resp.ar_ready !== 1'b1 || sub_req.ar_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_handshake_cycle got ready=%b sub_valid=%b exp ready=1 sub_valid=0",
                     mgr_resp.ar_ready, sub_req.ar_valid);
        end
        @(posedge clk_i); #1;
        mgr_req.ar_valid = 1'b0;
        mgr_req.ar       = '0;
        @(negedge clk_i);
        checks++;
        if (sub_req.ar_valid !== 1'b1 || sub_req.ar.addr !== 32'h1000 || sub_req.ar.id !== 4'd3 || mgr_resp.ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL ar_out got valid=%b addr=%h id=%0d ready=%b exp valid=1 addr=00001000 id=3 ready=1",
                     sub_req.ar_valid, sub_req.ar.addr, sub_req.ar.id, mgr_resp.ar_ready);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (sub_req.ar_valid !== 1'b0 || mgr_resp.ar_ready !== 1'b1) begin
            failures++;
            $display("FAIL ar_drain got valid=%b ready=%b exp valid=0 ready=1", sub_req.ar_valid, mgr_resp.ar_ready);
        end
        sub_resp.ar_ready = 1'b0;
        $display("test_ar_full done");
    endtask

    task automatic test_w_stream();
        int sent = 0;
        int rcvd = 0;
        int drops = 0;
        logic held = 1'b0;
        logic [31:0] held_data = '0;
        logic [31:0] exp;
        for (int c = 0; c < 80 && rcvd < 16; c++) begin
            @(posedge clk_i); #1;
            mgr_req.w_valid   = (sent < 16);
            mgr_req.w.data    = 32'(sent);
            mgr_req.w.strb    = '1;
            mgr_req.w.last    = (sent == 15);
            sub_resp.w_ready  = !(c >= 3 && c <= 6);
            @(negedge clk_i);
            if (held) begin
                checks++;
                if (sub_req.w_valid !== 1'b1 || sub_req.w.data !== held_data) begin
                    failures++;
                    $display("FAIL w_stable got valid=%b data=%h exp valid=1 data=%h", sub_req.w_valid, sub_req.w.data, held_data);
                end
            end
            checks++;
            if (mgr_resp.w_ready !== (wq.size() < 2)) begin
                failures++;
                $display("FAIL w_ready got=%b exp=%b occupancy=%0d", mgr_resp.w_ready, (wq.size() < 2), wq.size());
            end
            if (!mgr_resp.w_ready) drops++;
            if (sub_req.w_valid && sub_resp.w_ready) begin
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL w_extra_beat got=%h exp=none", sub_req.w.data);
                end else begin
                    exp = wq.pop_front();
                    if (sub_req.w.data !== exp) begin
                        failures++;
                        $display("FAIL w_data got=%h exp=%h", sub_req.w.data, exp);
                    end
                end
                $display("w beat out data=%h", sub_req.w.data);
                rcvd++;
            end
            held      = sub_req.w_valid && !sub_resp.w_ready;
            held_data = sub_req.w.data;
            if (mgr_req.w_valid && mgr_resp.w_ready) begin
                wq.push_back(32'(sent));
                sent++;
            end
        end
        mgr_req.w_valid = 1'b0;
        checks++;
        if (rcvd != 16 || wq.size() != 0) begin
            failures++;
            $display("FAIL w_count got=%0d exp=16 (leftover %0d)", rcvd, wq.size());
        end
        checks++;
        if (drops == 0) begin
            failures++;
            $display("FAIL w_backpressure got drops=%0d exp>0", drops);
        end
        $display("test_w_stream done");
    endtask

    task automatic test_r_half();
        int ridx = 0;
        int rcvd = 0;
        int first_in = -1;
        int prev_out = -1;
        logic [32:0] exp;
        for (int c = 0; c < 60 && rcvd < 8; c++) begin
            @(posedge clk_i); #1;
            sub_resp.r_valid = (ridx < 8);
            sub_resp.r.data  = 32'hC0DE_0000 + 32'(ridx);
            sub_resp.r.last  = (ridx == 7);
            sub_resp.r.id    = 4'h5;
            sub_resp.r.resp  = 2'b00;
            mgr_req.r_ready  = 1'b1;
            @(negedge clk_i);
            checks++;
            if (sub_req.r_ready !== (rq.size() == 0)) begin
                failures++;
                $display("FAIL r_in_ready got=%b exp=%b", sub_req.r_ready, (rq.size() == 0));
            end
            if (mgr_resp.r_valid && mgr_req.r_ready) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL r_extra_beat got=%h exp=none", mgr_resp.r.data);
                end else begin
                    exp = rq.pop_front();
                    if ({mgr_resp.r.last, mgr_resp.r.data} !== exp || mgr_resp.r.id !== 4'h5) begin
                        failures++;
                        $display("FAIL r_beat got last=%b data=%h id=%0d exp last=%b data=%h id=5",
                                 mgr_resp.r.last, mgr_resp.r.data, mgr_resp.r.id, exp[32], exp[31:0]);
                    end
                end
                if (prev_out >= 0) begin
                    checks++;
                    if (c - prev_out != 2) begin
                        failures++;
                        $display("FAIL r_spacing got=%0d exp=2", c - prev_out);
                    end
                end
                $display("r beat out data=%h last=%b cycle=%0d", mgr_resp.r.data, mgr_resp.r.last, c);
                prev_out = c;
                rcvd++;
            end
            if (sub_resp.r_valid && sub_req.r_ready) begin
                rq.push_back({sub_resp.r.last, sub_resp.r.data});
                if (first_in < 0) first_in = c;
                ridx++;
            end
        end
        sub_resp.r_valid = 1'b0;
        mgr_req.r_ready  = 1'b0;
        checks++;
        if (rcvd != 8) begin
            failures++;
            $display("FAIL r_count got=%0d exp=8", rcvd);
        end
        checks++;
        if (prev_out - first_in != 15) begin
            failures++;
            $display("FAIL r_total_cycles got=%0d exp=15", prev_out - first_in);
        end
        $display("test_r_half done");
    endtask

    task automatic test_b_fwd();
        int bidx = 0;
        int rcvd = 0;
        logic [5:0] exp;
        for (int c = 0; c < 80 && rcvd < 16; c++) begin
            @(posedge clk_i); #1;
            sub_resp.b_valid = (bidx < 16);
            sub_resp.b.id    = 4'(bidx);
            sub_resp.b.resp  = 2'(bidx >> 2);
            mgr_req.b_ready  = (c % 2 == 0);
            @(negedge clk_i);
            checks++;
            if (bq.size() == 1 && sub_req.b_ready !== mgr_req.b_ready) begin
                failures++;
                $display("FAIL b_ready_full got=%b exp=%b", sub_req.b_ready, mgr_req.b_ready);
            end else if (bq.size() == 0 && sub_req.b_ready !== 1'b1) begin
                failures++;
                $display("FAIL b_ready_empty got=%b exp=1", sub_req.b_ready);
            end
            checks++;
            if (mgr_resp.b_valid !== (bq.size() != 0)) begin
                failures++;
                $display("FAIL b_valid got=%b exp=%b", mgr_resp.b_valid, (bq.size() != 0));
            end
            if (mgr_resp.b_valid && mgr_req.b_ready) begin
                checks++;
                if (bq.size() == 0) begin
                    failures++;
                    $display("FAIL b_extra_beat got=%h exp=none", {mgr_resp.b.resp, mgr_resp.b.id});
                end else begin
                    exp = bq.pop_front();
                    if ({mgr_resp.b.resp, mgr_resp.b.id} !== exp) begin
                        failures++;
                        $display("FAIL b_beat got=%h exp=%h", {mgr_resp.b.resp, mgr_resp.b.id}, exp);
                    end
                end
                $display("b beat out id=%0d resp=%0d cycle=%0d", mgr_resp.b.id, mgr_resp.b.resp, c);
                rcvd++;
            end
            if (sub_resp.b_valid && sub_req.b_ready) begin
                bq.push_back({sub_resp.b.resp, sub_resp.b.id});
                bidx++;
            end
        end
        sub_resp.b_valid = 1'b0;
        mgr_req.b_ready  = 1'b0;
        checks++;
        if (rcvd != 16) begin
            failures++;
            $display("FAIL b_count got=%0d exp=16", rcvd);
        end
        $display("test_b_fwd done");
    endtask

    task automatic test_aw_bypass();
        logic [31:0] exp_addr;
        logic        exp_valid, exp_ready;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            exp_addr  = 32'hA000_0000 + 32'(i) * 32'h1111;
            exp_valid = (i % 2 == 0);
            exp_ready = (i / 2 == 0);
            mgr_req.aw.addr   = exp_addr;
            mgr_req.aw.id     = 4'(i + 8);
            mgr_req.aw_valid  = exp_valid;
            sub_resp.aw_ready = exp_ready;
            #1;
            checks++;
            if (sub_req.aw.addr !== exp_addr || sub_req.aw.id !== 4'(i + 8) ||
                sub_req.aw_valid !== exp_valid || mgr_resp.aw_ready !== exp_ready) begin
                failures++;
                $display("FAIL aw_bypass got addr=%h id=%0d valid=%b ready=%b exp addr=%h id=%0d valid=%b ready=%b",
                         sub_req.aw.addr, sub_req.aw.id, sub_req.aw_valid, mgr_resp.aw_ready,
                         exp_addr, i + 8, exp_valid, exp_ready);
            end
            $display("aw pattern %0d addr=%h", i, sub_req.aw.addr);
        end
        mgr_req.aw        = '0;
        mgr_req.aw_valid  = 1'b0;
        sub_resp.aw_ready = 1'b0;
        $display("test_aw_bypass done");
    endtask

    task automatic test_reset_mid();
        sub_resp.w_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            mgr_req.w_valid = 1'b1;
            mgr_req.w.data  = 32'hA0 + 32'(k);
            @(negedge clk_i);
            checks++;
            if (mgr_resp.w_ready !== 1'b1) begin
                failures++;
                $display("FAIL rst_fill_ready beat=%0d got=%b exp=1", k, mgr_resp.w_ready);
            end
        end
        @(posedge clk_i); #1;
        mgr_req.w_valid = 1'b0;
        @(negedge clk_i);
        checks++;
        if (sub_req.w_valid !== 1'b1 || sub_req.w.data !== 32'hA0 || mgr_resp.w_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_full got valid=%b data=%h ready=%b exp valid=1 data=000000a0 ready=0",
                     sub_req.w_valid, sub_req.w.data, mgr_resp.w_ready);
        end
        #2;
        arst_ni = 1'b0;
        #1;
        checks++;
        if (sub_req.w_valid !== 1'b0 || mgr_resp.w_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_async got valid=%b ready=%b exp valid=0 ready=1", sub_req.w_valid, mgr_resp.w_ready);
        end
        @(negedge clk_i);
        arst_ni          = 1'b1;
        sub_resp.w_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            checks++;
            if (sub_req.w_valid !== 1'b0 || mgr_resp.w_ready !== 1'b1) begin
                failures++;
                $display("FAIL rst_stale cycle=%0d got valid=%b ready=%b exp valid=0 ready=1",
                         k, sub_req.w_valid, mgr_resp.w_ready);
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        arst_ni  = 1'b0;
        mgr_req  = '0;
        sub_resp = '0;
        sub_resp.aw_ready = 1'b1;
        test_reset();
        test_ar_full();
        test_w_stream();
        test_r_half();
        test_b_fwd();
        test_aw_bypass();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
